// File: rtl/multiplier_radix_signed.sv
// Constant-time radix-2^DIGIT_BITS shift-add multiplier with per-operation
// unsigned / two's-complement selection and a start/busy/productDone handshake.
module multiplier_radix_signed #(
  parameter int WIDTH      = 32,
  parameter int DIGIT_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic [2*WIDTH-1:0]   product,
  output logic                 productDone,
  output logic                 busy
);

  localparam int N  = WIDTH / DIGIT_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int SW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state;
  logic [WIDTH:0]  mreg;
  logic [SW-1:0]   addend;
  logic [SW-1:0]   sum;
  logic [CW-1:0]   cnt;
  logic            sign_neg;

  logic            a_neg;
  logic            b_neg;
  logic [WIDTH:0]  a_mag;
  logic [WIDTH:0]  b_mag;
  logic [SW-1:0]   partial;
  logic [SW-1:0]   sum_neg;

  // Magnitudes carry one extra bit so the most negative operand stays exact.
  always_comb begin
    a_neg = signed_mode & multiplier[WIDTH-1];
    b_neg = signed_mode & multiplicand[WIDTH-1];
    a_mag = a_neg ? ({1'b0, ~multiplier} + (WIDTH+1)'(1))
                  : {1'b0, multiplier};
    b_mag = b_neg ? ({1'b0, ~multiplicand} + (WIDTH+1)'(1))
                  : {1'b0, multiplicand};
  end

  // addend already sits at the current digit position, so the digit product
  // is just a sum of its bit-shifted copies.
  always_comb begin
    partial = '0;
    for (int unsigned b = 0; b < DIGIT_BITS; b++) begin
      if (mreg[b]) partial = partial + (addend << b);
    end
  end

  assign sum_neg = ~sum + SW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mreg        <= '0;
      addend      <= '0;
      sum         <= '0;
      cnt         <= '0;
      sign_neg    <= 1'b0;
      product     <= '0;
      productDone <= 1'b0;
      busy        <= 1'b0;
    end else begin
      productDone <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mreg     <= a_mag;
            addend   <= SW'(b_mag);
            sum      <= '0;
            cnt      <= '0;
            sign_neg <= a_neg ^ b_neg;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // Fixed N iterations regardless of operand value.
          sum    <= sum + partial;
          mreg   <= mreg >> DIGIT_BITS;
          addend <= addend << DIGIT_BITS;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= FIX;
        end
        FIX: begin
          product     <= sign_neg ? sum_neg[2*WIDTH-1:0] : sum[2*WIDTH-1:0];
          productDone <= 1'b1;
          busy        <= 1'b0;
          cnt         <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
